memory_cycle_ecc: RTL and testbench
===================================

MEMORY_CYCLE_ECC -- requirements
Module: memory_cycle_ecc

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  DEPTH  64  data-memory words (power of two); address = ALU_Result[log2(DEPTH)+1:2].
  SCRUB_INTERVAL  256  clk cycles between scrub attempts.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state updates on posedge.
  rst  in  1  asynchronous, active-low reset.
  RegWriteM, MemWriteM, ResultSrcM  in  1 each  EX/MEM control (ResultSrcM=1: load).
  RD_M  in  5  destination register.
  ALU_ResultM_ECC, WriteDataM_ECC, PCPlus4M_ECC  in  39 each  EX/MEM SECDED codewords.
  ALU_ResultM_Out  out  32  corrected ALU result, combinational, for forwarding.
  RegWriteW, ResultSrcW  out  1 each  MEM/WB control.
  RD_W  out  5  MEM/WB destination.
  ALU_ResultW_ECC, ReadDataW_ECC, PCPlus4W_ECC  out  39 each  MEM/WB codewords.
  ecc_corrected_count  out  16  saturating count of cycles with a corrected single-bit error.
  ecc_fatal_flag  out  1  sticky flag for an uncorrectable (double-bit) error.
  scrub_busy  out  1  high while the scrub FSM is not in S_WAIT.

Function
REQ-003 Codeword: bit[38] = overall parity over bits[37:0]; bits[37:0] = Hamming positions 38..1; check bits at positions 1,2,4,8,16,32; data bits 0..31 fill the remaining positions in ascending order.
REQ-004 Each decoder SHALL classify: syndrome=0 and parity ok -> clean; parity bad -> single error, flip the syndrome position (syndrome=0: parity bit only); syndrome!=0 and parity ok -> double error, data passed uncorrected.
REQ-005 SHALL decode the three EX/MEM inputs and the memory read word in the same cycle, combinationally.
REQ-006 Memory SHALL store 39-bit codewords; read is combinational; write occurs on posedge.
REQ-007 Store (MemWriteM=1) SHALL write the re-encoded corrected WriteData to the corrected address, unless the ALU or WriteData decoder reports a double error; in that case the write is suppressed.
REQ-008 Load SHALL place the re-encoded corrected memory data into ReadDataW_ECC; on a non-load cycle ReadDataW_ECC SHALL be the encoding of 0.
REQ-009 The MEM/WB register SHALL capture controls, RD_M and re-encoded corrected ALU/PC+4 values every cycle; latency is exactly 1 cycle.
REQ-010 ecc_corrected_count SHALL increment by 1 in any cycle in which any decoder (pipeline or scrub) corrects; it saturates at 16'hFFFF.
REQ-011 ecc_fatal_flag SHALL set on any double error, including one found by scrub, and clear only on reset.
REQ-012 Scrub FSM states:
  S_WAIT: interval counter counts to SCRUB_INTERVAL-1 -> S_READ.
  S_READ: if pipeline idle (MemWriteM=0, ResultSrcM=0), decode mem[scrub_ptr]; single error -> S_FIX; clean or double -> advance ptr, go to S_WAIT; if pipeline busy, stay.
  S_FIX: if pipeline idle, write corrected codeword and advance ptr, go to S_WAIT; if busy, return to S_READ (re-read, because a store may have changed the word).
REQ-013 scrub_ptr SHALL wrap from DEPTH-1 to 0; the pipeline always has port priority.
REQ-014 A pipeline store and a scrub write in the same cycle SHALL never both occur.

Reset
REQ-015 While rst=0, all outputs and registers SHALL be 0, except that the W-stage codewords SHALL be the encoding of 0 (all-zero codeword).
REQ-016 Reset SHALL leave memory contents unchanged, put the FSM in S_WAIT, and zero the interval counter, scrub_ptr, count and flag; reset mid-scrub abandons any pending fix.

Verification
REQ-017 Store 0xDEADBEEF to addr 0x10, then load addr 0x10 -> ReadDataW_ECC decodes to 0xDEADBEEF one cycle after the load; count=0.
REQ-018 ALU_ResultM_ECC with position 5 flipped, value 0x00000040 -> ALU_ResultM_Out=0x40, ALU_ResultW_ECC clean, count=1.
REQ-019 Store with WriteDataM_ECC double error (positions 3,7) -> memory word unchanged, ecc_fatal_flag=1 and held until rst=0.
REQ-020 Preload mem[0] with a single flipped bit, idle for SCRUB_INTERVAL+2 cycles -> mem[0] corrected, count=1, scrub_ptr=1.
REQ-021 Continuous loads across a scrub window -> FSM stays in S_READ, no scrub write, load data correct; after the pipeline goes idle the scrub completes.
REQ-022 Assert rst=0 while the FSM is in S_FIX -> FSM returns to S_WAIT, count=0, flag=0, and the faulty word persists until the next scrub pass.

Source files
------------

// File: rtl/memory_cycle_ecc.sv
// memory_cycle_ecc: SECDED-protected MEM stage with data memory and background scrubber
module memory_cycle_ecc #(
  parameter int DEPTH          = 64,
  parameter int SCRUB_INTERVAL = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [38:0] ALU_ResultM_ECC,
  input  logic [38:0] WriteDataM_ECC,
  input  logic [38:0] PCPlus4M_ECC,
  output logic [31:0] ALU_ResultM_Out,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [38:0] ALU_ResultW_ECC,
  output logic [38:0] ReadDataW_ECC,
  output logic [38:0] PCPlus4W_ECC,
  output logic [15:0] ecc_corrected_count,
  output logic        ecc_fatal_flag,
  output logic        scrub_busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_WAIT, S_READ, S_FIX} state_t;
  function automatic logic [5:0] ecc_syn(input logic [38:0] c);
    logic [5:0] s;
    s = '0;
    for (int p = 1; p <= 38; p++) if (c[p-1]) s ^= 6'(p);
    return s;
  endfunction
  function automatic logic [38:0] ecc_enc(input logic [31:0] d);
    logic [38:0] c;
    logic [5:0] s;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k = k + 1;
      end
    s = ecc_syn(c);
    for (int b = 0; b < 6; b++) c[(1 << b) - 1] = s[b];
    c[38] = ^c[37:0];
    return c;
  endfunction
  function automatic logic [31:0] ecc_data(input logic [38:0] c);
    logic [31:0] d;
    int k;
    d = '0;
    k = 0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p-1];
        k = k + 1;
      end
    return d;
  endfunction
  // Odd overall parity means one flipped bit; syndrome 0 puts it on the parity bit itself.
  function automatic logic [38:0] ecc_fix(input logic [38:0] c);
    logic [38:0] f;
    logic [5:0] s;
    f = c;
    s = ecc_syn(c);
    if (^c) begin
      if (s == '0) f[38] = ~f[38];
      else if (s <= 6'd38) f[s-1] = ~f[s-1];
    end
    return f;
  endfunction
  function automatic logic is_dbl(input logic [38:0] c);
    return !(^c) && ecc_syn(c) != '0;
  endfunction
  logic [38:0] mem_q [DEPTH];
  state_t state_q, state_d;
  logic [31:0] ivl_q, ivl_d;
  logic [AW-1:0] scrub_ptr_q, scrub_ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic fatal_q, fatal_d;
  logic reg_write_q, reg_write_d, result_src_q, result_src_d;
  logic [4:0] rd_q, rd_d;
  logic [38:0] alu_w_q, alu_w_d, read_w_q, read_w_d, pc_w_q, pc_w_d;
  logic [31:0] alu_data;
  logic [AW-1:0] addr, mem_wa;
  logic [38:0] rd_raw, sc_raw, mem_wd;
  logic idle, store_ok, scrub_wr, sc_sgl, sc_dbl, pipe_sgl, pipe_dbl, mem_we;
  // Pipeline decode, memory port arbitration and MEM/WB next values
  always_comb begin
    alu_data = ecc_data(ecc_fix(ALU_ResultM_ECC));
    addr = alu_data[AW+1:2];
    rd_raw = mem_q[addr];
    sc_raw = mem_q[scrub_ptr_q];
    idle = !MemWriteM && !ResultSrcM;
    store_ok = MemWriteM && !is_dbl(ALU_ResultM_ECC) && !is_dbl(WriteDataM_ECC);
    pipe_sgl = ^ALU_ResultM_ECC || ^WriteDataM_ECC || ^PCPlus4M_ECC || (ResultSrcM && ^rd_raw);
    pipe_dbl = is_dbl(ALU_ResultM_ECC) || is_dbl(WriteDataM_ECC) || is_dbl(PCPlus4M_ECC) ||
               (ResultSrcM && is_dbl(rd_raw));
    mem_we = rst && (store_ok || scrub_wr);
    mem_wa = store_ok ? addr : scrub_ptr_q;
    mem_wd = store_ok ? ecc_enc(ecc_data(ecc_fix(WriteDataM_ECC))) : ecc_enc(ecc_data(ecc_fix(sc_raw)));
    reg_write_d = RegWriteM;
    result_src_d = ResultSrcM;
    rd_d = RD_M;
    alu_w_d = ecc_enc(alu_data);
    pc_w_d = ecc_enc(ecc_data(ecc_fix(PCPlus4M_ECC)));
    read_w_d = ResultSrcM ? ecc_enc(ecc_data(ecc_fix(rd_raw))) : '0;
    cnt_d = ((pipe_sgl || sc_sgl) && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    fatal_d = fatal_q || pipe_dbl || sc_dbl;
  end
  // Scrubber: wait an interval, then check one word and repair it only while the pipeline is idle
  always_comb begin
    state_d = state_q;
    ivl_d = ivl_q;
    scrub_ptr_d = scrub_ptr_q;
    scrub_wr = 1'b0;
    sc_sgl = 1'b0;
    sc_dbl = 1'b0;
    case (state_q)
      S_WAIT: begin
        ivl_d = (ivl_q == 32'(SCRUB_INTERVAL - 1)) ? '0 : ivl_q + 32'd1;
        state_d = (ivl_q == 32'(SCRUB_INTERVAL - 1)) ? S_READ : S_WAIT;
      end
      S_READ: if (idle) begin
        sc_sgl = ^sc_raw;
        sc_dbl = is_dbl(sc_raw);
        state_d = sc_sgl ? S_FIX : S_WAIT;
        scrub_ptr_d = sc_sgl ? scrub_ptr_q : scrub_ptr_q + 1'b1;
      end
      S_FIX: begin
        scrub_wr = idle;
        state_d = idle ? S_WAIT : S_READ;
        scrub_ptr_d = idle ? scrub_ptr_q + 1'b1 : scrub_ptr_q;
      end
      default: state_d = S_WAIT;
    endcase
  end
  // MEM/WB register, error status and scrubber state
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_WAIT;
      ivl_q <= '0;
      scrub_ptr_q <= '0;
      cnt_q <= '0;
      fatal_q <= 1'b0;
      reg_write_q <= 1'b0;
      result_src_q <= 1'b0;
      rd_q <= '0;
      alu_w_q <= '0;
      read_w_q <= '0;
      pc_w_q <= '0;
    end else begin
      state_q <= state_d;
      ivl_q <= ivl_d;
      scrub_ptr_q <= scrub_ptr_d;
      cnt_q <= cnt_d;
      fatal_q <= fatal_d;
      reg_write_q <= reg_write_d;
      result_src_q <= result_src_d;
      rd_q <= rd_d;
      alu_w_q <= alu_w_d;
      read_w_q <= read_w_d;
      pc_w_q <= pc_w_d;
    end
  // Codeword memory, deliberately not reset
  always_ff @(posedge clk)
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  assign ALU_ResultM_Out = rst ? alu_data : '0;
  assign RegWriteW = reg_write_q;
  assign ResultSrcW = result_src_q;
  assign RD_W = rd_q;
  assign ALU_ResultW_ECC = alu_w_q;
  assign ReadDataW_ECC = read_w_q;
  assign PCPlus4W_ECC = pc_w_q;
  assign ecc_corrected_count = cnt_q;
  assign ecc_fatal_flag = fatal_q;
  assign scrub_busy = state_q != S_WAIT;
endmodule

// File: tb/tb_memory_cycle_ecc.sv
// tb_memory_cycle_ecc: directed and randomized checks of the ECC memory stage against a brute-force model
module tb_memory_cycle_ecc;
  logic clk = 1'b0, rst = 1'b0;
  logic RegWriteM = 1'b0, MemWriteM = 1'b0, ResultSrcM = 1'b0;
  logic [4:0] RD_M = '0;
  logic [38:0] ALU_ResultM_ECC = '0, WriteDataM_ECC = '0, PCPlus4M_ECC = '0;
  logic [31:0] ALU_ResultM_Out;
  logic RegWriteW, ResultSrcW, ecc_fatal_flag, scrub_busy;
  logic [4:0] RD_W;
  logic [38:0] ALU_ResultW_ECC, ReadDataW_ECC, PCPlus4W_ECC;
  logic [15:0] ecc_corrected_count;
  int passed = 0, total = 0, n = 0, exp_cnt = 0;
  logic exp_fatal = 1'b0;
  logic [31:0] mm [64];
  logic [38:0] bad;

  memory_cycle_ecc dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
    .ALU_ResultM_ECC(ALU_ResultM_ECC), .WriteDataM_ECC(WriteDataM_ECC), .PCPlus4M_ECC(PCPlus4M_ECC),
    .ALU_ResultM_Out(ALU_ResultM_Out), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .ALU_ResultW_ECC(ALU_ResultW_ECC), .ReadDataW_ECC(ReadDataW_ECC), .PCPlus4W_ECC(PCPlus4W_ECC),
    .ecc_corrected_count(ecc_corrected_count), .ecc_fatal_flag(ecc_fatal_flag), .scrub_busy(scrub_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [38:0] tb_enc(input logic [31:0] d);
    logic [38:0] c;
    logic p;
    int k;
    c = '0;
    k = 0;
    for (int pos = 1; pos <= 38; pos++)
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[k];
        k++;
      end
    for (int b = 0; b < 6; b++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 38; pos++)
        if (((pos >> b) & 1) == 1 && pos != (1 << b)) p ^= c[pos-1];
      c[(1 << b) - 1] = p;
    end
    c[38] = ^c[37:0];
    return c;
  endfunction

  function automatic logic [31:0] tb_ext(input logic [38:0] c);
    logic [31:0] d;
    int k;
    d = '0;
    k = 0;
    for (int pos = 1; pos <= 38; pos++)
      if ((pos & (pos - 1)) != 0) begin
        d[k] = c[pos-1];
        k++;
      end
    return d;
  endfunction

  // kind: 0 clean, 1 one flip away from a valid codeword, 2 otherwise
  task automatic tb_dec(input logic [38:0] cw, output logic [31:0] d, output int kind);
    logic [38:0] t;
    d = tb_ext(cw);
    kind = (tb_enc(d) == cw) ? 0 : 2;
    for (int i = 0; i < 39; i++) begin
      t = cw ^ (39'd1 << i);
      if (kind == 2 && tb_enc(tb_ext(t)) == t) begin
        kind = 1;
        d = tb_ext(t);
      end
    end
  endtask

  function automatic logic [38:0] flip(input logic [38:0] c, input int nerr);
    int i, j;
    i = $urandom_range(0, 38);
    j = (i + 1 + $urandom_range(0, 37)) % 39;
    return nerr == 0 ? c : nerr == 1 ? c ^ (39'd1 << i) : c ^ (39'd1 << i) ^ (39'd1 << j);
  endfunction

  task automatic chk(input string tag, input logic [38:0] obs, input logic [38:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic drive(input logic mw, input logic ld, input logic rw, input logic [4:0] rd,
                       input logic [38:0] alu, input logic [38:0] wd, input logic [38:0] pc);
    MemWriteM = mw;
    ResultSrcM = ld;
    RegWriteM = rw;
    RD_M = rd;
    ALU_ResultM_ECC = alu;
    WriteDataM_ECC = wd;
    PCPlus4M_ECC = pc;
  endtask

  // One pipeline cycle checked against the model
  task automatic mstep(input string tag);
    logic [31:0] ad, wdd, pd;
    int ak, wk, pk;
    logic [5:0] a;
    logic [38:0] e_alu, e_pc, e_rd;
    logic e_rw, e_rs;
    logic [4:0] e_rdw;
    tb_dec(ALU_ResultM_ECC, ad, ak);
    tb_dec(WriteDataM_ECC, wdd, wk);
    tb_dec(PCPlus4M_ECC, pd, pk);
    #1;
    chk({tag, ":fwd"}, 39'(ALU_ResultM_Out), 39'(ad));
    a = ad[7:2];
    e_rd = ResultSrcM ? tb_enc(mm[a]) : '0;
    e_alu = tb_enc(ad);
    e_pc = tb_enc(pd);
    e_rw = RegWriteM;
    e_rs = ResultSrcM;
    e_rdw = RD_M;
    if (ak == 1 || wk == 1 || pk == 1) exp_cnt++;
    if (ak == 2 || wk == 2 || pk == 2) exp_fatal = 1'b1;
    if (MemWriteM && ak != 2 && wk != 2) mm[a] = wdd;
    cyc();
    chk({tag, ":aluW"}, ALU_ResultW_ECC, e_alu);
    chk({tag, ":pcW"}, PCPlus4W_ECC, e_pc);
    chk({tag, ":rdataW"}, ReadDataW_ECC, e_rd);
    chk({tag, ":ctlW"}, 39'({e_rw, e_rs, e_rdw}), 39'({RegWriteW, ResultSrcW, RD_W}) ^ 39'd0);
    chk({tag, ":count"}, 39'(ecc_corrected_count), 39'(exp_cnt));
    chk({tag, ":fatal"}, 39'(ecc_fatal_flag), 39'(exp_fatal));
  endtask

  initial begin
    int r;
    logic [5:0] a;
    logic [31:0] av;
    for (int i = 0; i < 64; i++) begin
      dut.mem_q[i] = '0;
      mm[i] = '0;
    end
    drive(1'b1, 1'b1, 1'b1, 5'd9, tb_enc(32'd5), tb_enc(32'd7), tb_enc(32'd8));
    cyc();
    cyc();
    chk("rst:fwd", 39'(ALU_ResultM_Out), 39'd0);
    chk("rst:aluW", ALU_ResultW_ECC, 39'd0);
    chk("rst:rdataW", ReadDataW_ECC, 39'd0);
    chk("rst:pcW", PCPlus4W_ECC, 39'd0);
    chk("rst:ctl", 39'({RegWriteW, ResultSrcW, RD_W, scrub_busy, ecc_fatal_flag}), 39'd0);
    chk("rst:count", 39'(ecc_corrected_count), 39'd0);
    chk("rst:mem4", dut.mem_q[4], 39'd0);
    rst = 1'b1;
    n = 0;
    drive(1'b1, 1'b0, 1'b0, 5'd0, tb_enc(32'h10), tb_enc(32'hDEADBEEF), tb_enc(32'h4));
    mstep("st");
    chk("st:mem4", dut.mem_q[4], tb_enc(32'hDEADBEEF));
    drive(1'b0, 1'b1, 1'b1, 5'd3, tb_enc(32'h10), '0, tb_enc(32'h8));
    mstep("ld");
    chk("ld:data", 39'(tb_ext(ReadDataW_ECC)), 39'(32'hDEADBEEF));
    chk("ld:count0", 39'(ecc_corrected_count), 39'd0);
    drive(1'b0, 1'b0, 1'b1, 5'd7, tb_enc(32'h40) ^ (39'd1 << 4), '0, tb_enc(32'h104));
    mstep("sec");
    chk("sec:aluW", ALU_ResultW_ECC, tb_enc(32'h40));
    chk("sec:count1", 39'(ecc_corrected_count), 39'd1);
    drive(1'b1, 1'b0, 1'b0, 5'd0, tb_enc(32'h10), tb_enc(32'h12345678) ^ (39'd1 << 2) ^ (39'd1 << 6), '0);
    mstep("ded");
    chk("ded:mem4", dut.mem_q[4], tb_enc(32'hDEADBEEF));
    chk("ded:flag", 39'(ecc_fatal_flag), 39'd1);
    while (n < 200) begin
      r = $urandom_range(0, 2);
      a = 6'($urandom_range(0, 63));
      av = ($urandom & 32'hFFFFFF03) | {24'd0, a, 2'b00};
      drive(r == 1, r == 2, 1'($urandom), 5'($urandom),
            flip(tb_enc(av), $urandom_range(0, 3) == 0 ? 1 : 0),
            flip(tb_enc($urandom), $urandom_range(0, 7) == 0 ? 1 : $urandom_range(0, 7) == 1 ? 2 : 0),
            flip(tb_enc($urandom), $urandom_range(0, 5) == 0 ? 1 : 0));
      mstep("rnd");
    end
    chk("rnd:flag_held", 39'(ecc_fatal_flag), 39'd1);
    drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0);
    rst = 1'b0;
    #1;
    chk("rst2:count", 39'(ecc_corrected_count), 39'd0);
    chk("rst2:flag", 39'(ecc_fatal_flag), 39'd0);
    bad = tb_enc(32'hA5A5A5A5) ^ (39'd1 << 9);
    dut.mem_q[0] = bad;
    mm[0] = 32'hA5A5A5A5;
    exp_cnt = 0;
    exp_fatal = 1'b0;
    cyc();
    rst = 1'b1;
    n = 0;
    drive(1'b0, 1'b1, 1'b0, 5'd1, tb_enc(32'h10), '0, '0);
    mstep("rst2:ld");
    chk("rst2:mem_kept", 39'(tb_ext(ReadDataW_ECC)), 39'(mm[4]));
    drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0);
    while (n < 260) cyc();
    chk("scrub:mem0", dut.mem_q[0], tb_enc(32'hA5A5A5A5));
    chk("scrub:count", 39'(ecc_corrected_count), 39'd1);
    chk("scrub:ptr", 39'(dut.scrub_ptr_q), 39'd1);
    chk("scrub:idle", 39'(scrub_busy), 39'd0);
    exp_cnt = 1;
    bad = tb_enc(32'h0F0F0F0F) ^ (39'd1 << 20);
    dut.mem_q[1] = bad;
    mm[1] = 32'h0F0F0F0F;
    while (n < 505) cyc();
    while (n < 530) begin
      drive(1'b0, 1'b1, 1'b1, 5'($urandom), tb_enc(32'h8), '0, tb_enc($urandom));
      mstep("stall");
      if (n >= 515) chk("stall:busy", 39'(scrub_busy), 39'd1);
    end
    chk("stall:mem1", dut.mem_q[1], bad);
    drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, '0);
    while (n < 535) cyc();
    chk("stall:mem1_fixed", dut.mem_q[1], tb_enc(32'h0F0F0F0F));
    chk("stall:count", 39'(ecc_corrected_count), 39'd2);
    chk("stall:ptr", 39'(dut.scrub_ptr_q), 39'd2);
    bad = tb_enc(32'h33CC33CC) ^ (39'd1 << 30);
    dut.mem_q[2] = bad;
    mm[2] = 32'h33CC33CC;
    while (n < 789) cyc();
    chk("fix:busy", 39'(scrub_busy), 39'd1);
    chk("fix:count", 39'(ecc_corrected_count), 39'd3);
    rst = 1'b0;
    #1;
    chk("fixrst:busy", 39'(scrub_busy), 39'd0);
    chk("fixrst:count", 39'(ecc_corrected_count), 39'd0);
    chk("fixrst:flag", 39'(ecc_fatal_flag), 39'd0);
    cyc();
    rst = 1'b1;
    n = 0;
    chk("fixrst:mem2", dut.mem_q[2], bad);
    while (n < 600) cyc();
    chk("pass2:mem2_pending", dut.mem_q[2], bad);
    chk("pass2:ptr", 39'(dut.scrub_ptr_q), 39'd2);
    while (n < 775) cyc();
    chk("pass2:mem2_fixed", dut.mem_q[2], tb_enc(32'h33CC33CC));
    chk("pass2:count", 39'(ecc_corrected_count), 39'd1);
    chk("pass2:ptr3", 39'(dut.scrub_ptr_q), 39'd3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
